// File: rtl/fir.sv
// 15-tap symmetric low-pass FIR with AXI4-Stream in/out, one result per accepted sample.
// Optional macro FIR_TLAST_EN: when defined, tlast travels with each sample to the output.
module fir #(
  parameter int NTAPS  = 15,
  parameter int DIN_W  = 16,
  parameter int DOUT_W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DIN_W-1:0]  s_axis_fir_tdata,
  input  logic [1:0]               s_axis_fir_tkeep,
  input  logic                     s_axis_fir_tlast,
  input  logic                     s_axis_fir_tvalid,
  output logic                     s_axis_fir_tready,
  output logic                     m_axis_fir_tvalid,
  input  logic                     m_axis_fir_tready,
  output logic                     m_axis_fir_tlast,
  output logic [3:0]               m_axis_fir_tkeep,
  output logic signed [DOUT_W-1:0] m_axis_fir_tdata
);

  localparam int ACC_W = 36;
  localparam int HALF  = NTAPS / 2;
  localparam int PRE_W = DIN_W + 1;

  localparam logic signed [DIN_W-1:0] COEF [NTAPS] = '{
    -16'sd868, 16'sd0, 16'sd1445, 16'sd0, -16'sd3060, 16'sd0, 16'sd10285, 16'sd16384,
    16'sd10285, 16'sd0, -16'sd3060, 16'sd0, 16'sd1445, 16'sd0, -16'sd868
  };

  logic signed [DIN_W-1:0]  x_q     [NTAPS];
  logic signed [DIN_W-1:0]  x_d     [NTAPS];
  logic signed [DIN_W-1:0]  x_new   [NTAPS];
  logic signed [PRE_W-1:0]  pre_add [HALF];
  logic signed [ACC_W-1:0]  acc;
  logic signed [DOUT_W-1:0] tdata_q, tdata_d;
  logic                     tvalid_q, tvalid_d;
  logic                     accept;

  assign s_axis_fir_tready = m_axis_fir_tready | ~tvalid_q;
  assign accept            = s_axis_fir_tvalid & s_axis_fir_tready;

  // Symmetric taps share one multiplier: x[k] and x[NTAPS-1-k] are pre-added first.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    x_d      = x_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    acc      = '0;

    x_new[0] = s_axis_fir_tdata;
    for (int k = 1; k < NTAPS; k++) x_new[k] = x_q[k-1];

    for (int k = 0; k < HALF; k++) begin
      pre_add[k] = PRE_W'(x_new[k]) + PRE_W'(x_new[NTAPS-1-k]);
      acc        = acc + ACC_W'(pre_add[k]) * ACC_W'(COEF[k]);
    end
    acc = acc + ACC_W'(x_new[HALF]) * ACC_W'(COEF[HALF]);

    if (accept) begin
      x_d      = x_new;
      tdata_d  = acc[DOUT_W-1:0];
      tvalid_d = 1'b1;
    end else if (m_axis_fir_tready) begin
      tvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the delay line is reset explicitly so a restarted stream carries no history.
      for (int k = 0; k < NTAPS; k++) x_q[k] <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      x_q      <= x_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
    end
  end

`ifdef FIR_TLAST_EN
  logic tlast_q, tlast_d;

  always_comb begin
    tlast_d = tlast_q;
    if (accept) tlast_d = s_axis_fir_tlast;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) tlast_q <= 1'b0;
    else        tlast_q <= tlast_d;
  end

  assign m_axis_fir_tlast = tlast_q;

  logic unused_bits;
  assign unused_bits = ^{s_axis_fir_tkeep, acc[ACC_W-1:DOUT_W]};
`else
  assign m_axis_fir_tlast = 1'b0;

  logic unused_bits;
  assign unused_bits = ^{s_axis_fir_tkeep, s_axis_fir_tlast, acc[ACC_W-1:DOUT_W]};
`endif

  assign m_axis_fir_tvalid = tvalid_q;
  assign m_axis_fir_tdata  = tdata_q;
  assign m_axis_fir_tkeep  = 4'hF;

endmodule

// File: tb/tb_fir.sv
// Scoreboard bench for fir: the driver queues expected results, a negedge monitor pops them.
module tb_fir;

  logic               clk = 1'b0;
  logic               reset;
  logic signed [15:0] s_tdata;
  logic [1:0]         s_tkeep;
  logic               s_tlast;
  logic               s_tvalid;
  logic               s_tready;
  logic               m_tvalid;
  logic               m_tready;
  logic               m_tlast;
  logic [3:0]         m_tkeep;
  logic signed [31:0] m_tdata;

  always #5 clk = ~clk;

  fir dut (
    .clk               (clk),
    .reset             (reset),
    .s_axis_fir_tdata  (s_tdata),
    .s_axis_fir_tkeep  (s_tkeep),
    .s_axis_fir_tlast  (s_tlast),
    .s_axis_fir_tvalid (s_tvalid),
    .s_axis_fir_tready (s_tready),
    .m_axis_fir_tvalid (m_tvalid),
    .m_axis_fir_tready (m_tready),
    .m_axis_fir_tlast  (m_tlast),
    .m_axis_fir_tkeep  (m_tkeep),
    .m_axis_fir_tdata  (m_tdata)
  );

  typedef struct packed {
    logic signed [31:0] data;
    logic               last;
  } exp_t;

  localparam logic signed [15:0] H [15] = '{
    -16'sd868, 16'sd0, 16'sd1445, 16'sd0, -16'sd3060, 16'sd0, 16'sd10285, 16'sd16384,
    16'sd10285, 16'sd0, -16'sd3060, 16'sd0, 16'sd1445, 16'sd0, -16'sd868
  };

  exp_t               sb [$];
  logic signed [15:0] mx [15];
  int                 checks   = 0;
  int                 failures = 0;
  bit                 rnd_done;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d (0x%h), expected %0d (0x%h)", name, $signed(act), act,
               $signed(req), req);
    end
  endtask

  function automatic void model_clear();
    for (int k = 0; k < 15; k++) mx[k] = '0;
  endfunction

  // Direct-form reference: shift, then full 15-product sum, low 32 bits.
  function automatic logic signed [31:0] model_step(input logic signed [15:0] d);
    longint sum;
    for (int k = 14; k > 0; k--) mx[k] = mx[k-1];
    mx[0] = d;
    sum = 0;
    for (int k = 0; k < 15; k++) sum += longint'(H[k]) * longint'(mx[k]);
    return sum[31:0];
  endfunction

  // Drive one beat; when it is accepted push either the hand value or the model value.
  task automatic send(input logic signed [15:0] d, input logic last, input bit use_exp,
                      input logic signed [31:0] e);
    int                 guard;
    exp_t               ent;
    logic signed [31:0] m;
    s_tdata  = d;
    s_tlast  = last;
    s_tvalid = 1'b1;
    guard    = 0;
    @(negedge clk);
    while (!s_tready && guard < 200) begin
      guard++;
      @(negedge clk);
    end
    if (!s_tready) begin
      check("send_accept_timeout", 32'd0, 32'd1);
    end else begin
      m        = model_step(d);
      ent.data = use_exp ? e : m;
`ifdef FIR_TLAST_EN
      ent.last = last;
`else
      ent.last = 1'b0;
`endif
      sb.push_back(ent);
    end
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    exp_t ent;
    if (reset && m_tvalid && m_tready) begin
      if (sb.size() == 0) begin
        check("unexpected_output", 32'd1, 32'd0);
      end else begin
        ent = sb.pop_front();
        check("out_data", m_tdata, ent.data);
        check("out_last", {31'd0, m_tlast}, {31'd0, ent.last});
      end
    end
  end

  initial begin
    logic signed [31:0] held;
    int                 g;

    reset    = 1'b0;
    s_tdata  = '0;
    s_tkeep  = 2'b11;
    s_tlast  = 1'b0;
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    rnd_done = 1'b0;
    model_clear();

    #50;
    check("rst_m_tvalid", {31'd0, m_tvalid}, 32'd0);
    check("rst_m_tdata",  m_tdata, 32'd0);
    check("rst_m_tkeep",  {28'd0, m_tkeep}, 32'hF);
    check("rst_s_tready", {31'd0, s_tready}, 32'd1);
    #50;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_m_tvalid", {31'd0, m_tvalid}, 32'd0);
    check("post_rst_m_tdata",  m_tdata, 32'd0);
    check("post_rst_m_tkeep",  {28'd0, m_tkeep}, 32'hF);
    check("post_rst_s_tready", {31'd0, s_tready}, 32'd1);

    // Impulse: coefficients appear in order, then zero.
    send(16'sd1, 1'b0, 1'b1, -32'sd868);
    for (int k = 1; k < 15; k++) send(16'sd0, 1'b0, 1'b1, 32'(H[k]));
    send(16'sd0, 1'b0, 1'b1, 32'sd0);
    idle(3);

    // DC settles at sum(h) * amplitude.
    for (int i = 0; i < 15; i++) send(16'sd32767, 1'b0, i == 14, 32'sd1048150796);
    for (int i = 0; i < 3; i++)  send(16'sd32767, 1'b0, 1'b1, 32'sd1048150796);
    for (int i = 0; i < 15; i++) send(16'sd1, 1'b0, i == 14, 32'sd31988);
    for (int i = 0; i < 2; i++)  send(16'sd1, 1'b0, 1'b1, 32'sd31988);
    idle(2);

    // tlast on the 8th sample only.
    for (int i = 0; i < 8; i++) send(16'(i * 1234 - 4000), i == 7, 1'b0, 32'sd0);
    idle(2);

    // Backpressure mid-stream.
    fork
      begin
        for (int i = 0; i < 20; i++) send(16'(i * 100 - 900), 1'b0, 1'b0, 32'sd0);
      end
      begin
        idle(4);
        m_tready = 1'b0;
        @(negedge clk);
        held = m_tdata;
        check("bp_valid_held", {31'd0, m_tvalid}, 32'd1);
        repeat (10) begin
          @(negedge clk);
          check("bp_s_tready_low", {31'd0, s_tready}, 32'd0);
          check("bp_data_held", m_tdata, held);
        end
        @(posedge clk);
        #1;
        m_tready = 1'b1;
      end
    join
    idle(2);

    // Valid gap: output valid drops one cycle after the last accept; history survives.
    send(16'sd5000, 1'b0, 1'b0, 32'sd0);
    send(-16'sd7000, 1'b0, 1'b0, 32'sd0);
    send(16'sd300, 1'b0, 1'b0, 32'sd0);
    @(negedge clk);
    check("gap_valid_last", {31'd0, m_tvalid}, 32'd1);
    repeat (4) begin
      @(negedge clk);
      check("gap_valid_low", {31'd0, m_tvalid}, 32'd0);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) send(16'(2000 - i * 1500), 1'b0, 1'b0, 32'sd0);
    idle(2);

    // Reset mid-stream with a result held under backpressure.
    for (int i = 0; i < 5; i++) send(16'(i * 3000 + 17), 1'b0, 1'b0, 32'sd0);
    m_tready = 1'b0;
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    sb.delete();
    model_clear();
    check("mid_rst_m_tvalid", {31'd0, m_tvalid}, 32'd0);
    check("mid_rst_m_tdata",  m_tdata, 32'd0);
    check("mid_rst_s_tready", {31'd0, s_tready}, 32'd1);
    check("mid_rst_m_tkeep",  {28'd0, m_tkeep}, 32'hF);
    #20;
    m_tready = 1'b1;
    @(negedge clk);
    #2;
    reset = 1'b1;
    @(posedge clk);
    #1;
    send(16'sd1, 1'b0, 1'b1, -32'sd868);
    send(16'sd0, 1'b0, 1'b1, 32'sd0);
    send(16'sd0, 1'b0, 1'b1, 32'sd1445);
    send(16'sd0, 1'b0, 1'b1, 32'sd0);
    idle(2);

    // Random samples with random downstream stalls.
    fork
      begin
        for (int i = 0; i < 200; i++) send(16'($urandom), 1'($urandom_range(0, 1)), 1'b0, 32'sd0);
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          m_tready = ($urandom_range(0, 3) != 0);
        end
        m_tready = 1'b1;
      end
    join

    g = 0;
    while (sb.size() != 0 && g < 1000) begin
      g++;
      @(negedge clk);
    end
    check("drain_empty", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
